// File: rtl/phy10g_lane_reset_supervisor.sv
// Per-lane 10G PHY bring-up supervisor: holds each lane in reset until QPLL
// lock, waits for a debounced resetdone, retries on timeout and latches failure.
module phy10g_lane_reset_supervisor #(
    parameter int LANES         = 8,
    parameter int RST_CYCLES    = 16,
    parameter int TIMEOUT       = 65536,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                clk156_i,
    input  logic                reset_i,
    input  logic                qplllock_i,
    input  logic [LANES-1:0]    lane_enable_i,
    input  logic [LANES-1:0]    lane_resetdone_i,
    input  logic [LANES-1:0]    retry_clear_i,
    output logic [LANES-1:0]    lane_reset_o,
    output logic [LANES-1:0]    lane_up_o,
    output logic [LANES-1:0]    lane_failed_o,
    output logic [LANES*RW-1:0] retry_count_o,
    output logic                all_up_o
);

    localparam int PMAX = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_RST,
        S_WAIT,
        S_STABLE,
        S_UP,
        S_FAIL
    } state_t;

    logic r_all_up;
    logic w_all_up_nx;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        state_t        r_state;
        state_t        w_state_nx;
        logic [PW-1:0] r_phase;
        logic [PW-1:0] w_phase_nx;
        logic [TW-1:0] r_tmo;
        logic [TW-1:0] w_tmo_nx;
        logic [RW-1:0] r_cnt;
        logic [RW-1:0] w_cnt_nx;
        logic          w_done;
        logic          w_clr;
        logic          w_tmo_hit;
        logic          w_retry;

        assign w_done    = lane_resetdone_i[g];
        assign w_clr     = retry_clear_i[g];
        assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

        always_ff @(posedge clk156_i) begin
            if (reset_i) begin
                r_state <= S_OFF;
                r_phase <= '0;
                r_tmo   <= '0;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nx;
                r_phase <= w_phase_nx;
                r_tmo   <= w_tmo_nx;
                r_cnt   <= w_cnt_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_phase_nx = r_phase;
            w_tmo_nx   = r_tmo;
            w_cnt_nx   = r_cnt;
            w_retry    = 1'b0;
            if (!lane_enable_i[g]) begin
                w_state_nx = S_OFF;
            end else if (!qplllock_i && (r_state != S_OFF) && (r_state != S_FAIL)) begin
                w_state_nx = S_OFF;
            end else begin
                if (w_clr) begin
                    w_cnt_nx = '0;
                end
                unique case (r_state)
                    S_OFF: begin
                        if (qplllock_i) begin
                            w_state_nx = S_RST;
                            w_phase_nx = '0;
                        end
                    end
                    S_RST: begin
                        if (r_phase == PW'(RST_CYCLES - 1)) begin
                            w_state_nx = S_WAIT;
                            w_tmo_nx   = '0;
                        end else begin
                            w_phase_nx = r_phase + PW'(1);
                        end
                    end
                    S_WAIT: begin
                        w_tmo_nx = r_tmo + TW'(1);
                        if (w_done && (STABLE_CYCLES == 1)) begin
                            w_state_nx = S_UP;
                        end else if (w_tmo_hit) begin
                            w_retry = 1'b1;
                        end else if (w_done) begin
                            w_state_nx = S_STABLE;
                            w_phase_nx = PW'(1);
                        end
                    end
                    S_STABLE: begin
                        // the timeout window spans bounces back into WAIT
                        w_tmo_nx = r_tmo + TW'(1);
                        if (w_done && (r_phase == PW'(STABLE_CYCLES - 1))) begin
                            w_state_nx = S_UP;
                        end else if (w_tmo_hit) begin
                            w_retry = 1'b1;
                        end else if (w_done) begin
                            w_phase_nx = r_phase + PW'(1);
                        end else begin
                            w_state_nx = S_WAIT;
                        end
                    end
                    S_UP: begin
                        if (!w_done) begin
                            w_retry = 1'b1;
                        end
                    end
                    S_FAIL: begin
                        if (w_clr) begin
                            w_state_nx = S_OFF;
                        end
                    end
                    default: begin
                        w_state_nx = S_OFF;
                    end
                endcase
                if (w_retry) begin
                    w_phase_nx = '0;
                    if (w_clr) begin
                        w_state_nx = S_RST;
                    end else if (r_cnt == RW'(MAX_RETRIES)) begin
                        w_state_nx = S_FAIL;
                    end else begin
                        w_cnt_nx   = r_cnt + RW'(1);
                        w_state_nx = S_RST;
                    end
                end
            end
        end

        assign lane_reset_o[g]            = (r_state == S_OFF) || (r_state == S_RST) ||
                                            (r_state == S_FAIL);
        assign lane_up_o[g]               = (r_state == S_UP);
        assign lane_failed_o[g]           = (r_state == S_FAIL);
        assign retry_count_o[g*RW +: RW]  = r_cnt;
    end

    assign w_all_up_nx = (|lane_enable_i) && (&(lane_up_o | ~lane_enable_i));

    always_ff @(posedge clk156_i) begin
        if (reset_i) begin
            r_all_up <= 1'b0;
        end else begin
            r_all_up <= w_all_up_nx;
        end
    end

    assign all_up_o = r_all_up;

endmodule

// File: tb/tb_phy10g_lane_reset_supervisor.sv
// Directed bench for phy10g_lane_reset_supervisor with a small 2-lane build
// and an expected-value queue checked against DUT outputs.
module tb_phy10g_lane_reset_supervisor;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       qplllock_i;
    logic [1:0] lane_enable_i;
    logic [1:0] lane_resetdone_i;
    logic [1:0] retry_clear_i;
    logic [1:0] lane_reset_o;
    logic [1:0] lane_up_o;
    logic [1:0] lane_failed_o;
    logic [3:0] retry_count_o;
    logic       all_up_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];
    logic [1:0]  saw_up;

    always #5 clk = ~clk;

    phy10g_lane_reset_supervisor #(
        .LANES(2),
        .RST_CYCLES(4),
        .TIMEOUT(20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES(2)
    ) dut (
        .clk156_i(clk),
        .reset_i(reset_i),
        .qplllock_i(qplllock_i),
        .lane_enable_i(lane_enable_i),
        .lane_resetdone_i(lane_resetdone_i),
        .retry_clear_i(retry_clear_i),
        .lane_reset_o(lane_reset_o),
        .lane_up_o(lane_up_o),
        .lane_failed_o(lane_failed_o),
        .retry_count_o(retry_count_o),
        .all_up_o(all_up_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        saw_up = saw_up | lane_up_o;
    endtask

    task automatic expect_v(string tag, logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic observe(logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_tests++;
        if (tag_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] e);
        expect_v(tag, e);
        observe(obs);
    endtask

    task automatic wait_rst(int lane, logic lvl, output int n);
        n = 0;
        while (lane_reset_o[lane] !== lvl && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_up(int lane, output int n);
        n = 0;
        while (lane_up_o[lane] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_allup(output int n);
        n = 0;
        while (all_up_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        reset_i          = 1'b1;
        qplllock_i       = 1'b1;
        lane_enable_i    = 2'b00;
        lane_resetdone_i = 2'b00;
        retry_clear_i    = 2'b00;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic one_timeout_window(string tag, int cnt);
        int n;
        expect_v({tag, "_rst_len"}, 4);
        wait_rst(0, 1'b0, n);
        observe(n);
        expect_v({tag, "_wait_len"}, 20);
        wait_rst(0, 1'b1, n);
        observe(n);
        chk({tag, "_count"}, retry_count_o, cnt);
    endtask

    initial begin
        int n;
        int total;
        saw_up = 2'b00;

        // reset state
        do_reset();
        reset_i = 1'b1;
        tick();
        chk("rst_lane_reset", lane_reset_o, 2'b11);
        chk("rst_lane_up", lane_up_o, 2'b00);
        chk("rst_failed", lane_failed_o, 2'b00);
        chk("rst_count", retry_count_o, 4'h0);
        chk("rst_all_up", all_up_o, 1'b0);
        reset_i = 1'b0;

        // bring-up of lane 0 only
        lane_enable_i = 2'b01;
        tick();
        expect_v("bring_rst_len", 4);
        wait_rst(0, 1'b0, n);
        observe(n);
        repeat (3) tick();
        lane_resetdone_i = 2'b01;
        expect_v("bring_stable_len", 8);
        wait_up(0, n);
        observe(n);
        chk("bring_all_up_lag", all_up_o, 1'b0);
        tick();
        chk("bring_all_up", all_up_o, 1'b1);
        chk("bring_lane1_rst", lane_reset_o[1], 1'b1);
        chk("bring_lane1_up", lane_up_o[1], 1'b0);

        // timeout and fail
        do_reset();
        lane_enable_i = 2'b01;
        tick();
        one_timeout_window("tmo1", 1);
        one_timeout_window("tmo2", 2);
        one_timeout_window("tmo3", 2);
        chk("tmo_failed", lane_failed_o, 2'b01);
        chk("tmo_fail_reset", lane_reset_o[0], 1'b1);
        repeat (3) tick();
        chk("tmo_fail_hold", lane_failed_o, 2'b01);
        retry_clear_i = 2'b01;
        tick();
        retry_clear_i = 2'b00;
        chk("clr_failed", lane_failed_o, 2'b00);
        chk("clr_count", retry_count_o, 4'h0);
        chk("clr_reset", lane_reset_o[0], 1'b1);
        expect_v("clr_restart_len", 5);
        wait_rst(0, 1'b0, n);
        observe(n);

        // bounce inside the timeout window
        do_reset();
        lane_enable_i = 2'b01;
        tick();
        wait_rst(0, 1'b0, n);
        saw_up = 2'b00;
        repeat (8) tick();
        lane_resetdone_i = 2'b01;
        repeat (5) tick();
        lane_resetdone_i = 2'b00;
        tick();
        lane_resetdone_i = 2'b01;
        expect_v("bounce_tail", 6);
        wait_rst(0, 1'b1, n);
        observe(n);
        total = 14 + n;
        chk("bounce_total", total, 20);
        chk("bounce_no_up", saw_up, 2'b00);
        chk("bounce_count", retry_count_o, 4'h1);

        // reset asserted mid-STABLE
        lane_resetdone_i = 2'b00;
        wait_rst(0, 1'b0, n);
        lane_resetdone_i = 2'b01;
        repeat (3) tick();
        chk("mid_stable_not_up", lane_up_o, 2'b00);
        reset_i = 1'b1;
        tick();
        chk("mid_rst_reset", lane_reset_o, 2'b11);
        chk("mid_rst_up", lane_up_o, 2'b00);
        chk("mid_rst_failed", lane_failed_o, 2'b00);
        chk("mid_rst_count", retry_count_o, 4'h0);
        chk("mid_rst_all_up", all_up_o, 1'b0);
        reset_i = 1'b0;

        // link drop on lane 0 with both lanes up
        do_reset();
        lane_enable_i    = 2'b11;
        lane_resetdone_i = 2'b11;
        tick();
        expect_v("drop_reach_all_up", 1);
        wait_allup(n);
        observe(all_up_o);
        chk("drop_up_before", lane_up_o, 2'b11);
        lane_resetdone_i = 2'b10;
        tick();
        lane_resetdone_i = 2'b11;
        chk("drop_up", lane_up_o, 2'b10);
        chk("drop_reset", lane_reset_o, 2'b01);
        chk("drop_count", retry_count_o, 4'h1);
        chk("drop_all_up_lag", all_up_o, 1'b1);
        tick();
        chk("drop_all_up_fall", all_up_o, 1'b0);

        // QPLL loss with both lanes up
        expect_v("qpll_reach_all_up", 1);
        wait_allup(n);
        observe(all_up_o);
        qplllock_i = 1'b0;
        tick();
        chk("qpll_off_reset", lane_reset_o, 2'b11);
        chk("qpll_off_up", lane_up_o, 2'b00);
        repeat (9) tick();
        chk("qpll_count_kept", retry_count_o, 4'h1);
        chk("qpll_failed", lane_failed_o, 2'b00);
        qplllock_i = 1'b1;
        tick();
        repeat (3) tick();
        chk("qpll_rst_hold", lane_reset_o, 2'b11);
        tick();
        chk("qpll_rst_release", lane_reset_o, 2'b00);

        // clear coinciding with the third timeout
        do_reset();
        lane_enable_i = 2'b01;
        tick();
        one_timeout_window("sim1", 1);
        one_timeout_window("sim2", 2);
        wait_rst(0, 1'b0, n);
        repeat (19) tick();
        chk("sim_pre_failed", lane_failed_o, 2'b00);
        retry_clear_i = 2'b01;
        tick();
        retry_clear_i = 2'b00;
        chk("sim_failed", lane_failed_o, 2'b00);
        chk("sim_count", retry_count_o, 4'h0);
        chk("sim_reset", lane_reset_o[0], 1'b1);
        expect_v("sim_rst_len", 4);
        wait_rst(0, 1'b0, n);
        observe(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phy10g_lane_reset_supervisor.md
Name: phy10g_lane_reset_supervisor

Overview:
- Parametrised per-lane bring-up supervisor for multi-lane 10G PHY arrays (generalises fixed 8-lane, two-quad builds to any lane count).
- Replaces the single AND of lane resetdone flags with a per-lane FSM. Each lane FSM holds the lane in reset until QPLL lock, waits with a timeout for resetdone, and debounces it.
- On failure it retries the lane's reset up to a limit, then latches a failed flag. A healthy aggregate flag is exported.
- Sits in the clk156 domain between shared PHY logic and the lane instances.

Parameters:
LANES, 8, number of supervised lanes (1..32)
RST_CYCLES, 16, cycles lane_reset_o is held in RST state (>=1)
TIMEOUT, 65536, max cycles from WAIT entry to UP before a retry (> STABLE_CYCLES)
STABLE_CYCLES, 256, consecutive resetdone-high cycles required to declare lane up (>=1)
MAX_RETRIES, 3, retries permitted before FAIL (>=0); RW = $clog2(MAX_RETRIES+1), min 1

Ports:
clk156_i  in  1  single clock; all logic on rising edge
reset_i  in  1  synchronous, active-high reset
qplllock_i  in  1  AND of all quad PLL locks, synchronous to clk156_i
lane_enable_i  in  LANES  per-lane enable
lane_resetdone_i  in  LANES  per-lane resetdone, already synchronised to clk156_i
retry_clear_i  in  LANES  per-lane single-cycle pulse: clear retry count / leave FAIL
lane_reset_o  out  LANES  per-lane PHY reset request, active-high
lane_up_o  out  LANES  lane declared up
lane_failed_o  out  LANES  lane exhausted retries
retry_count_o  out  LANES*RW  per-lane retry count, lane n at [n*RW +: RW]
all_up_o  out  1  >=1 lane enabled and every enabled lane up

Behaviour:
- Reset: all lanes OFF. lane_reset_o all ones. lane_up_o, lane_failed_o, retry_count_o and all_up_o are 0.
- Per-lane Moore FSM with states OFF, RST, WAIT, STABLE, UP, FAIL. Outputs decode the registered state, so they change on the same edge as the state.
- lane_reset_o=1 in OFF, RST and FAIL. lane_up_o=1 only in UP. lane_failed_o=1 only in FAIL.
- Each lane has a phase counter (RST length / stable count) and a timeout counter. Counter widths are $clog2 of their limit.
- OFF -> RST when lane_enable_i=1 and qplllock_i=1. Phase counter is cleared.
- RST: held exactly RST_CYCLES cycles, then WAIT. Timeout counter cleared on WAIT entry.
- WAIT: timeout counter increments each cycle. resetdone sampled 1 -> STABLE with stable count 1.
- STABLE: resetdone 1 -> count+1; on reaching STABLE_CYCLES -> UP. resetdone 0 -> WAIT. The timeout counter keeps running through WAIT/STABLE and is not cleared on a bounce.
- Retry event in WAIT/STABLE: timeout counter reaches TIMEOUT-1 without UP entry.
- Retry event in UP: resetdone sampled 0.
- On a retry event: if count==MAX_RETRIES -> FAIL (count unchanged); else count+1 and -> RST.
- FAIL: exits only via retry_clear_i (count:=0, -> OFF) or disable.
- Per-lane priority (highest first):
  1. reset_i
  2. lane_enable_i=0 -> OFF
  3. qplllock_i=0 in RST/WAIT/STABLE/UP -> OFF, no retry counted
  4. retry_clear_i -> count:=0. In FAIL, -> OFF. In other states, the state transition proceeds normally, and a simultaneous retry event goes to RST with count 0, never FAIL.
  5. normal transitions
- Retry count is preserved across disable and QPLL loss. It is cleared only by reset_i or retry_clear_i.
- all_up_o is registered: it reflects lane_up_o/lane_enable_i of the previous cycle. It is 0 if no lane is enabled.
- Lanes are fully independent. No shared counters, and all lanes are evaluated in the same cycle.
- TIMEOUT and STABLE_CYCLES boundaries are exact. Bench checks cycle counts precisely.

Test Plan:
All scenarios use LANES=2, RST_CYCLES=4, TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Bring-up: reset released; lane_enable_i=01, qplllock_i=1 -> lane_reset_o[0] stays high exactly 4 cycles after leaving OFF. resetdone raised 3 cycles into WAIT -> lane_up_o[0] rises 8 cycles after first high sample; all_up_o rises 1 cycle later; lane 1 stays OFF with reset high.
- Timeout/fail: lane 0 enabled, resetdone held 0 -> three 20-cycle WAIT windows. retry_count_o goes 0,1,2, then lane_failed_o[0]=1 with count 2 and lane_reset_o[0]=1. retry_clear_i pulse -> OFF, count 0, restarts RST.
- Bounce: resetdone toggles 1 for 5 cycles, 0 for 1, then stays 1 -> no UP before timeout (5+1+8 > 20-entry offset as scheduled). Retry fires at cycle 20 of WAIT entry, count=1.
- Link drop: lane UP, resetdone drops 1 cycle -> next edge RST, count+1, lane_up_o=0, all_up_o falls one cycle later.
- QPLL loss: both lanes UP, qplllock_i=0 for 10 cycles -> both OFF, counts unchanged. Lock restored -> both re-enter RST on the same edge.
- Simultaneous: retry_clear_i asserted on the exact cycle of the third timeout -> count 0, state RST, lane_failed_o stays 0. Reset mid-STABLE -> all outputs at reset values next cycle.
